// File: rtl/yari_mem_arbiter.sv
// Three-port (DC/IC/AUX) arbiter onto one memory port: locked, starvation-bounded priority.
// Request paths are combinational; grant lock and wait counters are registered.
module yari_mem_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int CW       = 4
) (
  input  logic        clock,
  input  logic        rst,

  input  logic [29:0] dc_address,
  input  logic        dc_read,
  input  logic        dc_write,
  input  logic [31:0] dc_writedata,
  input  logic [3:0]  dc_writedatamask,
  output logic        dc_waitrequest,
  output logic [31:0] dc_readdata,
  output logic        dc_readdatavalid,

  input  logic [29:0] ic_address,
  input  logic        ic_read,
  input  logic        ic_write,
  input  logic [31:0] ic_writedata,
  input  logic [3:0]  ic_writedatamask,
  output logic        ic_waitrequest,
  output logic [31:0] ic_readdata,
  output logic        ic_readdatavalid,

  input  logic [29:0] aux_address,
  input  logic        aux_read,
  input  logic        aux_write,
  input  logic [31:0] aux_writedata,
  input  logic [3:0]  aux_writedatamask,
  output logic        aux_waitrequest,
  output logic [31:0] aux_readdata,
  output logic        aux_readdatavalid,

  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid
);

  localparam logic [1:0]    ID_NONE = 2'd0;
  localparam logic [1:0]    ID_DC   = 2'd1;
  localparam logic [1:0]    ID_IC   = 2'd2;
  localparam logic [1:0]    ID_AUX  = 2'd3;
  localparam logic [CW-1:0] WMAX    = CW'(MAX_WAIT);

  logic          locked_q, locked_d;
  logic [1:0]    lock_id_q, lock_id_d;
  logic [CW-1:0] ic_cnt_q, ic_cnt_d;
  logic [CW-1:0] aux_cnt_q, aux_cnt_d;
  logic          aux_first_q, aux_first_d;

  logic       stb_dc, stb_ic, stb_aux;
  logic       starve_ic, starve_aux;
  logic [1:0] gnt;
  logic       gnt_stb;
  logic       accept;

  // IC is a read-only master; its write strobe plays no part in arbitration.
  logic unused_ic_write;
  assign unused_ic_write = ic_write;

  assign stb_dc     = dc_read | dc_write;
  assign stb_ic     = ic_read;
  assign stb_aux    = aux_read | aux_write;
  assign starve_ic  = stb_ic  && (ic_cnt_q  == WMAX);
  assign starve_aux = stb_aux && (aux_cnt_q == WMAX);

  always_comb begin
    gnt = ID_NONE;
    if (locked_q) begin
      gnt = lock_id_q;
    end else if (starve_ic && starve_aux) begin
      gnt = aux_first_q ? ID_AUX : ID_IC;
    end else if (starve_ic) begin
      gnt = ID_IC;
    end else if (starve_aux) begin
      gnt = ID_AUX;
    end else if (stb_dc) begin
      gnt = ID_DC;
    end else if (stb_aux) begin
      gnt = ID_AUX;
    end else if (stb_ic) begin
      gnt = ID_IC;
    end
  end

  always_comb begin
    gnt_stb = 1'b0;
    case (gnt)
      ID_DC:   gnt_stb = stb_dc;
      ID_IC:   gnt_stb = stb_ic;
      ID_AUX:  gnt_stb = stb_aux;
      default: gnt_stb = 1'b0;
    endcase
  end

  assign accept = gnt_stb & ~mem_waitrequest;

  always_comb begin
    mem_id            = ID_NONE;
    mem_address       = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_writedata     = '0;
    mem_writedatamask = '0;
    if (gnt_stb) begin
      mem_id = gnt;
      case (gnt)
        ID_DC: begin
          mem_address       = dc_address;
          mem_read          = dc_read;
          mem_write         = dc_write;
          mem_writedata     = dc_writedata;
          mem_writedatamask = dc_writedatamask;
        end
        ID_IC: begin
          mem_address       = ic_address;
          mem_read          = ic_read;
          mem_writedata     = ic_writedata;
          mem_writedatamask = ic_writedatamask;
        end
        ID_AUX: begin
          mem_address       = aux_address;
          mem_read          = aux_read;
          mem_write         = aux_write;
          mem_writedata     = aux_writedata;
          mem_writedatamask = aux_writedatamask;
        end
        default: mem_id = ID_NONE;
      endcase
    end
  end

  assign dc_waitrequest  = (gnt != ID_DC)  | mem_waitrequest;
  assign ic_waitrequest  = (gnt != ID_IC)  | mem_waitrequest;
  assign aux_waitrequest = (gnt != ID_AUX) | mem_waitrequest;

  assign dc_readdata       = mem_readdata;
  assign ic_readdata       = mem_readdata;
  assign aux_readdata      = mem_readdata;
  assign dc_readdatavalid  = (mem_readdataid == ID_DC);
  assign ic_readdatavalid  = (mem_readdataid == ID_IC);
  assign aux_readdatavalid = (mem_readdataid == ID_AUX);

  always_comb begin
    // A stalled strobe holds the grant; accept or a dropped strobe releases it.
    locked_d  = gnt_stb & mem_waitrequest;
    lock_id_d = locked_d ? gnt : lock_id_q;

    ic_cnt_d = '0;
    if (stb_ic && !(accept && gnt == ID_IC)) begin
      ic_cnt_d = (ic_cnt_q == WMAX) ? WMAX : ic_cnt_q + 1'b1;
    end
    aux_cnt_d = '0;
    if (stb_aux && !(accept && gnt == ID_AUX)) begin
      aux_cnt_d = (aux_cnt_q == WMAX) ? WMAX : aux_cnt_q + 1'b1;
    end

    // Remembers which port saturated first while both are starving; IC wins a tie.
    aux_first_d = 1'b0;
    if (ic_cnt_d == WMAX && aux_cnt_d == WMAX) begin
      if (ic_cnt_q == WMAX && aux_cnt_q == WMAX) begin
        aux_first_d = aux_first_q;
      end else if (aux_cnt_q == WMAX) begin
        aux_first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      locked_q    <= 1'b0;
      lock_id_q   <= ID_NONE;
      ic_cnt_q    <= '0;
      aux_cnt_q   <= '0;
      aux_first_q <= 1'b0;
    end else begin
      locked_q    <= locked_d;
      lock_id_q   <= lock_id_d;
      ic_cnt_q    <= ic_cnt_d;
      aux_cnt_q   <= aux_cnt_d;
      aux_first_q <= aux_first_d;
    end
  end

endmodule

// File: tb/tb_yari_mem_arbiter.sv
// Bench for yari_mem_arbiter: directed scenarios plus randomized masters checked
// every cycle against an age/timestamp model of the arbitration rules.
module tb_yari_mem_arbiter;

  localparam int MAX_WAIT = 15;

  logic        clock = 1'b0;
  logic        rst;
  logic [29:0] dc_address, ic_address, aux_address;
  logic        dc_read, ic_read, aux_read;
  logic        dc_write, ic_write, aux_write;
  logic [31:0] dc_writedata, ic_writedata, aux_writedata;
  logic [3:0]  dc_writedatamask, ic_writedatamask, aux_writedatamask;
  logic        dc_waitrequest, ic_waitrequest, aux_waitrequest;
  logic [31:0] dc_readdata, ic_readdata, aux_readdata;
  logic        dc_readdatavalid, ic_readdatavalid, aux_readdatavalid;
  logic        mem_waitrequest;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;

  yari_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .CW(4)) dut (
    .clock(clock), .rst(rst),
    .dc_address(dc_address), .dc_read(dc_read), .dc_write(dc_write),
    .dc_writedata(dc_writedata), .dc_writedatamask(dc_writedatamask),
    .dc_waitrequest(dc_waitrequest), .dc_readdata(dc_readdata),
    .dc_readdatavalid(dc_readdatavalid),
    .ic_address(ic_address), .ic_read(ic_read), .ic_write(ic_write),
    .ic_writedata(ic_writedata), .ic_writedatamask(ic_writedatamask),
    .ic_waitrequest(ic_waitrequest), .ic_readdata(ic_readdata),
    .ic_readdatavalid(ic_readdatavalid),
    .aux_address(aux_address), .aux_read(aux_read), .aux_write(aux_write),
    .aux_writedata(aux_writedata), .aux_writedatamask(aux_writedatamask),
    .aux_waitrequest(aux_waitrequest), .aux_readdata(aux_readdata),
    .aux_readdatavalid(aux_readdatavalid),
    .mem_waitrequest(mem_waitrequest), .mem_id(mem_id),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask),
    .mem_readdata(mem_readdata), .mem_readdataid(mem_readdataid)
  );

  always #5 clock = ~clock;

  // Port index 0=DC, 1=IC, 2=AUX; port ID is index+1.
  logic        req_vld [3];
  logic        req_rd  [3];
  logic [29:0] req_addr[3];
  logic [31:0] req_dat [3];
  logic [3:0]  req_msk [3];
  logic        wait_in;
  logic [1:0]  rdid;
  logic [31:0] rddata;

  int age[3];
  int since[3];
  int owner;
  int cyc;
  int last_acc;
  int n_vec;
  int n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic new_req(input int p);
    req_vld[p]  = 1'b1;
    req_rd[p]   = (p == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    req_addr[p] = 30'($urandom);
    req_dat[p]  = $urandom;
    req_msk[p]  = 4'($urandom);
  endtask

  task automatic drive();
    dc_address        = req_addr[0];
    dc_read           = req_vld[0] & req_rd[0];
    dc_write          = req_vld[0] & ~req_rd[0];
    dc_writedata      = req_dat[0];
    dc_writedatamask  = req_msk[0];
    ic_address        = req_addr[1];
    ic_read           = req_vld[1];
    ic_write          = 1'b0;
    ic_writedata      = req_dat[1];
    ic_writedatamask  = req_msk[1];
    aux_address       = req_addr[2];
    aux_read          = req_vld[2] & req_rd[2];
    aux_write         = req_vld[2] & ~req_rd[2];
    aux_writedata     = req_dat[2];
    aux_writedatamask = req_msk[2];
    mem_waitrequest   = wait_in;
    mem_readdataid    = rdid;
    mem_readdata      = rddata;
  endtask

  // Grant from the rules: stalled owner keeps it; else longest-starving of IC/AUX
  // (IC on equal start), else DC, AUX, IC among requesters.
  function automatic int model_gnt();
    logic s_ic, s_aux;
    if (owner != 0) return owner;
    s_ic  = req_vld[1] && age[1] >= MAX_WAIT;
    s_aux = req_vld[2] && age[2] >= MAX_WAIT;
    if (s_ic && s_aux) return (since[1] <= since[2]) ? 2 : 3;
    if (s_ic)  return 2;
    if (s_aux) return 3;
    if (req_vld[0]) return 1;
    if (req_vld[2]) return 3;
    if (req_vld[1]) return 2;
    return 0;
  endfunction

  task automatic step();
    int   g;
    logic gs;
    logic acc;
    @(negedge clock);
    drive();
    #1;
    if (!rst) begin
      for (int p = 0; p < 3; p++) begin
        age[p] = 0;
        since[p] = 0;
      end
      owner = 0;
    end
    g  = model_gnt();
    gs = (g != 0) && req_vld[g-1];
    chk("mem_id", 32'(mem_id), gs ? 32'(g) : 32'd0);
    chk("mem_read", 32'(mem_read), 32'(gs && req_rd[g-1]));
    chk("mem_write", 32'(mem_write), 32'(gs && g != 2 && !req_rd[g-1]));
    chk("mem_address", 32'(mem_address), gs ? 32'(req_addr[g-1]) : 32'd0);
    if (!(gs && g == 2)) begin
      chk("mem_writedata", mem_writedata, gs ? req_dat[g-1] : 32'd0);
      chk("mem_writedatamask", 32'(mem_writedatamask), gs ? 32'(req_msk[g-1]) : 32'd0);
    end
    chk("dc_waitrequest",  32'(dc_waitrequest),  32'(g != 1 || wait_in));
    chk("ic_waitrequest",  32'(ic_waitrequest),  32'(g != 2 || wait_in));
    chk("aux_waitrequest", 32'(aux_waitrequest), 32'(g != 3 || wait_in));
    chk("dc_readdatavalid",  32'(dc_readdatavalid),  32'(rdid == 2'd1));
    chk("ic_readdatavalid",  32'(ic_readdatavalid),  32'(rdid == 2'd2));
    chk("aux_readdatavalid", 32'(aux_readdatavalid), 32'(rdid == 2'd3));
    chk("dc_readdata",  dc_readdata,  rddata);
    chk("ic_readdata",  ic_readdata,  rddata);
    chk("aux_readdata", aux_readdata, rddata);

    last_acc = 0;
    if (rst) begin
      acc = gs && !wait_in;
      for (int p = 0; p < 3; p++) begin
        if (req_vld[p] && !(acc && g == p + 1)) begin
          age[p]++;
          if (age[p] == MAX_WAIT) since[p] = cyc + 1;
        end else begin
          age[p] = 0;
        end
      end
      owner = (gs && wait_in) ? g : 0;
      if (acc) begin
        req_vld[g-1] = 1'b0;
        last_acc = g;
      end
    end
    cyc++;
  endtask

  task automatic idle();
    for (int p = 0; p < 3; p++) req_vld[p] = 1'b0;
    wait_in = 1'b0;
    step();
  endtask

  logic [31:0] rd_data_tab[4];
  logic [2:0]  rd_vld_tab [4];
  int          ic_acc_cnt;
  int          ic_acc_cyc;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; owner = 0; last_acc = 0;
    for (int p = 0; p < 3; p++) begin
      req_vld[p] = 1'b0; req_rd[p] = 1'b1; req_addr[p] = '0;
      req_dat[p] = '0; req_msk[p] = '0; age[p] = 0; since[p] = 0;
    end
    wait_in = 1'b0; rdid = 2'd0; rddata = 32'h0;
    rst = 1'b0;
    drive();

    // Reset: DC and IC reading, DC drives memory combinationally.
    new_req(0); req_rd[0] = 1'b1; new_req(1);
    step();
    chk("rst_mem_read", 32'(mem_read), 32'd1);
    chk("rst_mem_id", 32'(mem_id), 32'd1);
    step();
    for (int p = 0; p < 3; p++) req_vld[p] = 1'b0;
    rst = 1'b1;
    step();
    chk("idle_mem_id", 32'(mem_id), 32'd0);
    chk("idle_mem_address", 32'(mem_address), 32'd0);

    // Priority with all three reading.
    new_req(0); req_rd[0] = 1'b1; new_req(1); new_req(2); req_rd[2] = 1'b1;
    step(); chk("prio_c0_id", 32'(mem_id), 32'd1);
    step(); chk("prio_c1_id", 32'(mem_id), 32'd3);
    step(); chk("prio_c2_id", 32'(mem_id), 32'd2);
    idle();

    // Lock: IC stalled for three cycles holds the port against DC.
    wait_in = 1'b1;
    new_req(1); req_addr[1] = 30'h1234;
    step(); chk("lock_c0_id", 32'(mem_id), 32'd2);
    new_req(0);
    step(); chk("lock_c1_id", 32'(mem_id), 32'd2);
    chk("lock_c1_addr", 32'(mem_address), 32'h1234);
    step(); chk("lock_c2_id", 32'(mem_id), 32'd2);
    wait_in = 1'b0;
    step(); chk("lock_c3_acc", 32'(last_acc), 32'd2);
    chk("lock_c3_addr", 32'(mem_address), 32'h1234);
    step(); chk("lock_c4_acc", 32'(last_acc), 32'd1);
    idle();

    // Starvation under back-to-back DC traffic.
    new_req(1); ic_acc_cnt = 0; ic_acc_cyc = -1;
    for (int c = 0; c < 18; c++) begin
      new_req(0);
      step();
      if (!ic_waitrequest) begin
        ic_acc_cnt++;
        ic_acc_cyc = c;
      end
      if (c == 16) chk("starve_c16_id", 32'(mem_id), 32'd1);
    end
    chk("starve_ic_acc_cnt", 32'(ic_acc_cnt), 32'd1);
    chk("starve_ic_acc_cyc", 32'(ic_acc_cyc), 32'd15);
    idle();

    // Simultaneous starvation: IC first, then AUX.
    new_req(1); new_req(2);
    for (int c = 0; c < 18; c++) begin
      new_req(0);
      step();
      if (c == 14) chk("sim_c14_id", 32'(mem_id), 32'd1);
      if (c == 15) chk("sim_c15_id", 32'(mem_id), 32'd2);
      if (c == 16) chk("sim_c16_id", 32'(mem_id), 32'd3);
      if (c == 17) chk("sim_c17_id", 32'(mem_id), 32'd1);
    end
    idle();

    // Read routing by ID.
    rd_data_tab[0] = 32'hAAAA_0001; rd_data_tab[1] = 32'hBBBB_0002;
    rd_data_tab[2] = 32'hCCCC_0003; rd_data_tab[3] = 32'hDDDD_0004;
    rd_vld_tab[0] = 3'b001; rd_vld_tab[1] = 3'b010;
    rd_vld_tab[2] = 3'b100; rd_vld_tab[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      rdid = (i == 3) ? 2'd0 : 2'(i + 1);
      rddata = rd_data_tab[i];
      step();
      chk("route_vld", 32'({aux_readdatavalid, ic_readdatavalid, dc_readdatavalid}),
          32'(rd_vld_tab[i]));
      chk("route_data", dc_readdata, rd_data_tab[i]);
    end
    rdid = 2'd0;

    // Reset asserted mid-lock releases the port at once.
    wait_in = 1'b1;
    new_req(1);
    step(); chk("rlock_c0_id", 32'(mem_id), 32'd2);
    new_req(0); req_rd[0] = 1'b1;
    rst = 1'b0;
    step(); chk("rlock_rst_id", 32'(mem_id), 32'd1);
    rst = 1'b1; wait_in = 1'b0;
    step(); chk("rlock_rel_acc", 32'(last_acc), 32'd1);
    step(); chk("rlock_ic_acc", 32'(last_acc), 32'd2);
    idle();

    // Randomized masters holding requests until accepted.
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 3; p++)
        if (!req_vld[p] && $urandom_range(0, 99) < 45) new_req(p);
      wait_in = ($urandom_range(0, 99) < 30);
      rdid    = 2'($urandom_range(0, 3));
      rddata  = $urandom;
      step();
    end
    rdid = 2'd0; wait_in = 1'b0;
    for (int n = 0; n < 20; n++) step();
    idle();
    chk("drain_idle_id", 32'(mem_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
